req_encoder_8to3: RTL and testbench

- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder.
- Collects one-hot or multi-hot request bits into a sticky pending register.
- Issues one 3-bit index per serviced request over a valid/ready handshake and clears each bit once its index is accepted.
- Sits between request-raising logic and any consumer that wants binary indices, e.g. to feed the decoder on the far side of a link.

---
 rtl/req_encoder_8to3_pkg.sv | 12 +
 rtl/req_encoder_8to3_if.sv | 8 +
 rtl/req_encoder_8to3_pick8.sv | 19 +
 rtl/req_encoder_8to3.sv | 48 ++++
 tb/tb_req_encoder_8to3.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/req_encoder_8to3_pkg.sv
// enc_pkg: shared widths and index/one-hot mapping helpers for the 8-to-3 encoder
package enc_pkg;
  localparam int N = 8;
  localparam int W = 3;
  function automatic logic [W-1:0] lsb_index(input logic [N-1:0] v);
    lsb_index = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) lsb_index = i[W-1:0];
  endfunction
  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    onehot = N'(1) << idx;
  endfunction
endpackage

// File: rtl/req_encoder_8to3_if.sv
// req_encoder_8to3_if: valid/ready channel carrying the encoded request index
interface req_encoder_8to3_if;
  logic [enc_pkg::W-1:0] code_out;
  logic code_valid;
  logic code_ready;
  modport master (output code_out, output code_valid, input code_ready);
  modport slave (input code_out, input code_valid, output code_ready);
endinterface

// File: rtl/req_encoder_8to3_pick8.sv
// enc_pick8: picks the lowest set bit of i_e, searched from i_ptr when round-robin
module enc_pick8 import enc_pkg::*; #(
  parameter bit RR = 1'b0
) (
  input  logic [N-1:0] i_e,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_found
);
  logic [W-1:0]   w_sh;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  assign w_sh    = RR ? i_ptr : '0;
  // rotate right so the pointer lands on bit 0, search, then add the pointer back
  assign w_dbl   = {i_e, i_e} >> w_sh;
  assign w_rot   = w_dbl[N-1:0];
  assign o_idx   = lsb_index(w_rot) + w_sh;
  assign o_found = |i_e;
endmodule

// File: rtl/req_encoder_8to3.sv
// req_encoder_8to3: sticky pending requests issued one index at a time over valid/ready
module req_encoder_8to3 import enc_pkg::*; #(
  parameter bit RR = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              req_in,
  input  logic                      flush,
  req_encoder_8to3_if.master        enc,
  output logic [N-1:0]              pending,
  output logic                      idle
);
  logic [N-1:0] r_pending, w_oh, w_elig;
  logic [W-1:0] r_code, r_ptr, w_idx;
  logic         r_valid, w_acc, w_found, w_load;
  assign w_oh   = onehot(r_code);
  assign w_acc  = r_valid & enc.code_ready;
  // the index already in the output slot must not be picked a second time
  assign w_elig = r_pending & ~(r_valid ? w_oh : '0);
  assign w_load = (!r_valid | w_acc) & w_found;
  enc_pick8 #(.RR(RR)) u_pick (
    .i_e     (w_elig),
    .i_ptr   (r_ptr),
    .o_idx   (w_idx),
    .o_found (w_found)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pending <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_ptr     <= '0;
    end else if (flush) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~(w_acc ? w_oh : '0)) | req_in;
      if (w_load) begin
        r_code  <= w_idx;
        r_valid <= 1'b1;
        r_ptr   <= w_idx + W'(1);
      end else if (w_acc) r_valid <= 1'b0;
    end
  assign enc.code_out   = r_code;
  assign enc.code_valid = r_valid;
  assign pending        = r_pending;
  assign idle           = ~|r_pending & ~r_valid;
endmodule

// File: tb/tb_req_encoder_8to3.sv
// tb_req_encoder_8to3: directed scoreboard bench for fixed-priority and round-robin encoders
module tb_req_encoder_8to3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] req0 = '0, req1 = '0, pend0, pend1;
  logic fl0 = 1'b0, fl1 = 1'b0, idle0, idle1;
  int n_assert = 0, n_fail = 0;
  logic [2:0] q0[$], q1[$];
  req_encoder_8to3_if if0();
  req_encoder_8to3_if if1();
  req_encoder_8to3 #(.RR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_in(req0), .flush(fl0),
    .enc(if0.master), .pending(pend0), .idle(idle0)
  );
  req_encoder_8to3 #(.RR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_in(req1), .flush(fl1),
    .enc(if1.master), .pending(pend1), .idle(idle1)
  );
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (if0.code_valid && if0.code_ready) begin
        n_assert++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL dut0_unexpected: got %0d expected none", if0.code_out);
        end else begin
          e = q0.pop_front();
          if (if0.code_out !== e) begin
            n_fail++;
            $display("FAIL dut0_code: got %0d expected %0d", if0.code_out, e);
          end
        end
      end
      if (if1.code_valid && if1.code_ready) begin
        n_assert++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL dut1_unexpected: got %0d expected none", if1.code_out);
        end else begin
          e = q1.pop_front();
          if (if1.code_out !== e) begin
            n_fail++;
            $display("FAIL dut1_code: got %0d expected %0d", if1.code_out, e);
          end
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    if0.code_ready = 1'b0;
    if1.code_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rst_valid0", 8'(if0.code_valid), 8'h00);
    chk("rst_pend0", pend0, 8'h00);
    chk("rst_idle0", 8'(idle0), 8'h01);
    chk("rst_valid1", 8'(if1.code_valid), 8'h00);
    chk("rst_idle1", 8'(idle1), 8'h01);
    // single request: two-cycle latency to code_valid
    if0.code_ready = 1'b1;
    req0 = 8'h10; q0.push_back(3'd4);
    step(1); req0 = '0;
    chk("single_pend", pend0, 8'h10);
    chk("single_nolat", 8'(if0.code_valid), 8'h00);
    step(1);
    chk("single_valid", 8'(if0.code_valid), 8'h01);
    chk("single_code", 8'(if0.code_out), 8'h04);
    step(1);
    chk("single_pend_clr", pend0, 8'h00);
    chk("single_idle", 8'(idle0), 8'h01);
    // multi-hot fixed priority
    req0 = 8'hA5;
    foreach (q0[i]) q0.delete(i);
    q0.push_back(3'd0); q0.push_back(3'd2); q0.push_back(3'd5); q0.push_back(3'd7);
    step(1); req0 = '0;
    step(4);
    chk("a5_last", 8'(if0.code_out), 8'h07);
    step(1);
    chk("a5_idle", 8'(idle0), 8'h01);
    // all eight lines back-to-back
    req0 = 8'hFF;
    for (int i = 0; i < 8; i++) q0.push_back(3'(i));
    step(1); req0 = '0;
    step(8);
    chk("ff_last", 8'(if0.code_out), 8'h07);
    chk("ff_busy", 8'(idle0), 8'h00);
    step(1);
    chk("ff_idle", 8'(idle0), 8'h01);
    // backpressure
    if0.code_ready = 1'b0;
    req0 = 8'h06;
    step(1); req0 = '0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_code", 8'(if0.code_out), 8'h01);
      chk("bp_valid", 8'(if0.code_valid), 8'h01);
      chk("bp_pend", pend0, 8'h06);
      step(1);
    end
    if0.code_ready = 1'b1;
    q0.push_back(3'd1); q0.push_back(3'd2);
    step(1);
    chk("bp_pend_04", pend0, 8'h04);
    chk("bp_code2", 8'(if0.code_out), 8'h02);
    step(1);
    chk("bp_pend_00", pend0, 8'h00);
    chk("bp_drop", 8'(if0.code_valid), 8'h00);
    // set wins over clear on the same bit
    req0 = 8'h08; q0.push_back(3'd3); q0.push_back(3'd3);
    step(1); req0 = '0;
    step(1); req0 = 8'h08;
    step(1); req0 = '0;
    chk("coll_pend", pend0, 8'h08);
    chk("coll_drop", 8'(if0.code_valid), 8'h00);
    step(2);
    chk("coll_idle", 8'(idle0), 8'h01);
    // repeated request on a pending bit is absorbed
    if0.code_ready = 1'b0;
    req0 = 8'h02;
    step(3); req0 = '0;
    chk("abs_pend", pend0, 8'h02);
    chk("abs_code", 8'(if0.code_out), 8'h01);
    if0.code_ready = 1'b1; q0.push_back(3'd1);
    step(1);
    chk("abs_idle", 8'(idle0), 8'h01);
    // round-robin alternation, flush, retained pointer
    if1.code_ready = 1'b1;
    req1 = 8'h81;
    q1.push_back(3'd0); q1.push_back(3'd7); q1.push_back(3'd0); q1.push_back(3'd7);
    step(6);
    req1 = '0; if1.code_ready = 1'b0; fl1 = 1'b1;
    step(1); fl1 = 1'b0;
    chk("fl_pend", pend1, 8'h00);
    chk("fl_valid", 8'(if1.code_valid), 8'h00);
    req1 = 8'h81; if1.code_ready = 1'b1;
    q1.push_back(3'd7); q1.push_back(3'd0);
    step(1); req1 = '0;
    step(1);
    chk("rr_ptr_code", 8'(if1.code_out), 8'h07);
    step(2);
    chk("rr_idle", 8'(idle1), 8'h01);
    step(3);
    chk("q0_empty", 8'(q0.size()), 8'h00);
    chk("q1_empty", 8'(q1.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
